// File: rtl/spi_capture_responder.sv
// spi_capture_responder: buffers camera pixels in a FIFO and returns one
// 16-bit word per SPI transfer (mode 0, MSB first) to an external master.
//
// Ports:
//   SYSCLK, RESET          - sole clock (rising edge), synchronous active-high reset
//   cs, SPI_CLK            - SPI chip select (active low) and clock, asynchronous
//   miso                   - serial data to master, registered
//   capture_en             - pixels accepted only while high
//   pix_valid/pix_sof/pix_data - pixel strobe, start-of-frame flag, 12-bit value
//   fifo_level             - current FIFO occupancy
//   overflow, underrun     - sticky error flags, cleared only by RESET
//   abort_count            - truncated transfers, saturating at 255
//
// Optional build macro SPI_CAPTURE_STATUS_TAG_EN: when defined the FIFO keeps
// the sof flag and words are {valid, sof, 2'b00, pixel}; otherwise words are
// {4'b0000, pixel}. The empty (underrun) word is 16'h0000 in both builds.
module spi_capture_responder #(
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                          SYSCLK,
  input  logic                          RESET,
  input  logic                          cs,
  input  logic                          SPI_CLK,
  output logic                          miso,
  input  logic                          capture_en,
  input  logic                          pix_valid,
  input  logic                          pix_sof,
  input  logic [11:0]                   pix_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          underrun,
  output logic [7:0]                    abort_count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
`ifdef SPI_CAPTURE_STATUS_TAG_EN
  localparam int unsigned EW = 13;
`else
  localparam int unsigned EW = 12;
`endif

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

  state_t state, state_next;

  // Input synchronizers plus one edge-detect register per line
  logic [SYNC_STAGES-1:0] cs_sync, sclk_sync;
  logic                   cs_d, sclk_d;
  logic                   cs_s, sclk_s;
  logic                   cs_fall, cs_rise, sclk_rise, sclk_fall;

  always_ff @(posedge SYSCLK) begin
    if (RESET) begin
      cs_sync   <= '1;
      sclk_sync <= '0;
      cs_d      <= 1'b1;
      sclk_d    <= 1'b0;
    end else begin
      cs_sync[0]   <= cs;
      sclk_sync[0] <= SPI_CLK;
      for (int i = 1; i < int'(SYNC_STAGES); i++) begin
        cs_sync[i]   <= cs_sync[i-1];
        sclk_sync[i] <= sclk_sync[i-1];
      end
      cs_d   <= cs_s;
      sclk_d <= sclk_s;
    end
  end

  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_fall   = cs_d & ~cs_s;
  assign cs_rise   = ~cs_d & cs_s;
  assign sclk_rise = ~sclk_d & sclk_s;
  assign sclk_fall = sclk_d & ~sclk_s;

  // Pixel FIFO
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          full, empty, push_req, push, pop;
  logic [EW-1:0] wr_data, rd_data;
  logic [15:0]   head_word, load_word;

  assign full     = (fifo_level == LW'(FIFO_DEPTH));
  assign empty    = (fifo_level == '0);
  assign push_req = pix_valid & capture_en;
  assign push     = push_req & ~full;
  assign rd_data  = mem[rd_ptr];

`ifdef SPI_CAPTURE_STATUS_TAG_EN
  assign wr_data   = {pix_sof, pix_data};
  assign head_word = {1'b1, rd_data[12], 2'b00, rd_data[11:0]};
`else
  logic unused_sof;
  assign unused_sof = pix_sof;
  assign wr_data    = pix_data;
  assign head_word  = {4'b0000, rd_data};
`endif

  assign load_word = empty ? 16'h0000 : head_word;

  always_ff @(posedge SYSCLK) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally since FIFO_DEPTH is a power of two
  always_ff @(posedge SYSCLK) begin
    if (RESET) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: fifo_level <= fifo_level;
      endcase
      if (push_req && full) overflow <= 1'b1;
    end
  end

  // Transfer FSM: state register
  logic [4:0] bit_cnt;
  logic       bits_left;

  assign bits_left = (bit_cnt < 5'd16);

  always_ff @(posedge SYSCLK) begin
    if (RESET) state <= IDLE;
    else       state <= state_next;
  end

  // Transfer FSM: next state
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (cs_fall) state_next = LOAD;
      LOAD:    state_next = SHIFT;
      SHIFT:   if (cs_rise) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Transfer FSM: control outputs
  logic load_c, shift_c, count_c, abort_c, end_c;

  always_comb begin
    load_c  = 1'b0;
    shift_c = 1'b0;
    count_c = 1'b0;
    abort_c = 1'b0;
    end_c   = 1'b0;
    case (state)
      LOAD:  load_c = 1'b1;
      SHIFT: begin
        end_c   = cs_rise;
        abort_c = cs_rise & bits_left;
        count_c = ~cs_rise & sclk_rise & bits_left;
        shift_c = ~cs_rise & sclk_fall & bits_left;
      end
      default: ;
    endcase
  end

  assign pop = load_c & ~empty;

  // Shift register, bit counter, miso and status registers
  logic [15:0] shift_reg;

  always_ff @(posedge SYSCLK) begin
    if (RESET) begin
      shift_reg   <= '0;
      bit_cnt     <= '0;
      miso        <= 1'b0;
      underrun    <= 1'b0;
      abort_count <= '0;
    end else begin
      if (load_c) begin
        shift_reg <= load_word;
        bit_cnt   <= '0;
        miso      <= load_word[15];
        if (empty) underrun <= 1'b1;
      end else if (end_c) begin
        // Word is discarded on any transfer end; nothing is re-pushed
        shift_reg <= '0;
        miso      <= 1'b0;
      end else begin
        if (count_c) bit_cnt <= bit_cnt + 5'd1;
        if (shift_c) begin
          shift_reg <= {shift_reg[14:0], 1'b0};
          miso      <= shift_reg[14];
        end
      end
      if (abort_c && abort_count != 8'hFF) abort_count <= abort_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_spi_capture_responder.sv
// Directed self-checking bench for spi_capture_responder: acts as the SPI
// master (10 SYSCLK half-period) and the pixel source.
module tb_spi_capture_responder;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned LW    = $clog2(DEPTH) + 1;

  logic          SYSCLK = 1'b0;
  logic          RESET;
  logic          cs;
  logic          SPI_CLK;
  logic          miso;
  logic          capture_en;
  logic          pix_valid;
  logic          pix_sof;
  logic [11:0]   pix_data;
  logic [LW-1:0] fifo_level;
  logic          overflow;
  logic          underrun;
  logic [7:0]    abort_count;

  int pass_cnt  = 0;
  int total_cnt = 0;

  spi_capture_responder #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
    .SYSCLK      (SYSCLK),
    .RESET       (RESET),
    .cs          (cs),
    .SPI_CLK     (SPI_CLK),
    .miso        (miso),
    .capture_en  (capture_en),
    .pix_valid   (pix_valid),
    .pix_sof     (pix_sof),
    .pix_data    (pix_data),
    .fifo_level  (fifo_level),
    .overflow    (overflow),
    .underrun    (underrun),
    .abort_count (abort_count)
  );

  always #5 SYSCLK = ~SYSCLK;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] exp_word(input logic sof, input logic [11:0] px);
    logic unused_sof;
    unused_sof = sof;
`ifdef SPI_CAPTURE_STATUS_TAG_EN
    return {1'b1, sof, 2'b00, px};
`else
    return {4'b0000, px};
`endif
  endfunction

  // Inputs change 1 time unit after the rising edge
  task automatic tick();
    @(posedge SYSCLK);
    #1;
  endtask

  task automatic push_pixel(input logic en, input logic sof, input logic [11:0] px);
    capture_en = en;
    pix_valid  = 1'b1;
    pix_sof    = sof;
    pix_data   = px;
    tick();
    pix_valid  = 1'b0;
    capture_en = 1'b1;
  endtask

  // Clock n bits with cs already low; master samples miso on SPI_CLK rise
  task automatic spi_bits(input int n, output logic [15:0] rx);
    rx = '0;
    for (int i = 0; i < n; i++) begin
      SPI_CLK = 1'b1;
      rx = {rx[14:0], miso};
      repeat (10) tick();
      SPI_CLK = 1'b0;
      repeat (10) tick();
    end
  endtask

  // Full or truncated transfer; optionally pushes one pixel at setup tick push_at
  task automatic spi_xfer(input int n, input bit do_push, input int push_at,
                          input logic [11:0] px, output logic [15:0] rx);
    cs = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (do_push && i == push_at) begin
        pix_valid = 1'b1;
        pix_sof   = 1'b0;
        pix_data  = px;
      end
      tick();
      pix_valid = 1'b0;
    end
    spi_bits(n, rx);
    repeat (4) tick();
    cs = 1'b1;
    repeat (12) tick();
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    repeat (3) tick();
    RESET = 1'b0;
    tick();
    total_cnt++; if (miso !== 1'b0) $display("FAIL reset_miso got=%b exp=0", miso); else pass_cnt++;
    total_cnt++; if (fifo_level !== LW'(0)) $display("FAIL reset_level got=%0d exp=0", fifo_level); else pass_cnt++;
    total_cnt++; if (overflow !== 1'b0) $display("FAIL reset_overflow got=%b exp=0", overflow); else pass_cnt++;
    total_cnt++; if (underrun !== 1'b0) $display("FAIL reset_underrun got=%b exp=0", underrun); else pass_cnt++;
    total_cnt++; if (abort_count !== 8'd0) $display("FAIL reset_abort got=%0d exp=0", abort_count); else pass_cnt++;
  endtask

  task automatic test_single_transfer();
    logic [15:0] rx;
    push_pixel(1'b1, 1'b0, 12'hABC);
    total_cnt++; if (fifo_level !== LW'(1)) $display("FAIL single_level_pre got=%0d exp=1", fifo_level); else pass_cnt++;
    spi_xfer(16, 1'b0, 0, 12'h000, rx);
    total_cnt++; if (rx !== exp_word(1'b0, 12'hABC)) $display("FAIL single_word got=%h exp=%h", rx, exp_word(1'b0, 12'hABC)); else pass_cnt++;
    total_cnt++; if (fifo_level !== LW'(0)) $display("FAIL single_level_post got=%0d exp=0", fifo_level); else pass_cnt++;
    total_cnt++; if (underrun !== 1'b0) $display("FAIL single_underrun got=%b exp=0", underrun); else pass_cnt++;
  endtask

  task automatic test_capture_gate();
    for (int i = 0; i < 3; i++) push_pixel(1'b0, 1'b0, 12'h111);
    total_cnt++; if (fifo_level !== LW'(0)) $display("FAIL gate_level got=%0d exp=0", fifo_level); else pass_cnt++;
    total_cnt++; if (overflow !== 1'b0) $display("FAIL gate_overflow got=%b exp=0", overflow); else pass_cnt++;
  endtask

  task automatic test_underrun();
    logic [15:0] rx;
    spi_xfer(16, 1'b0, 0, 12'h000, rx);
    total_cnt++; if (rx !== 16'h0000) $display("FAIL underrun_word got=%h exp=0000", rx); else pass_cnt++;
    total_cnt++; if (underrun !== 1'b1) $display("FAIL underrun_flag got=%b exp=1", underrun); else pass_cnt++;
    total_cnt++; if (fifo_level !== LW'(0)) $display("FAIL underrun_level got=%0d exp=0", fifo_level); else pass_cnt++;
  endtask

  task automatic test_overflow();
    logic [15:0] rx;
    for (int i = 0; i <= int'(DEPTH); i++) push_pixel(1'b1, (i == 0), 12'h100 + 12'(i));
    total_cnt++; if (fifo_level !== LW'(DEPTH)) $display("FAIL ovf_level got=%0d exp=%0d", fifo_level, DEPTH); else pass_cnt++;
    total_cnt++; if (overflow !== 1'b1) $display("FAIL ovf_flag got=%b exp=1", overflow); else pass_cnt++;
    for (int i = 0; i < int'(DEPTH); i++) begin
      spi_xfer(16, 1'b0, 0, 12'h000, rx);
      total_cnt++;
      if (rx !== exp_word((i == 0), 12'h100 + 12'(i)))
        $display("FAIL ovf_word[%0d] got=%h exp=%h", i, rx, exp_word((i == 0), 12'h100 + 12'(i)));
      else pass_cnt++;
    end
    total_cnt++; if (fifo_level !== LW'(0)) $display("FAIL ovf_drained got=%0d exp=0", fifo_level); else pass_cnt++;
    spi_xfer(16, 1'b0, 0, 12'h000, rx);
    total_cnt++; if (rx !== 16'h0000) $display("FAIL ovf_dropped got=%h exp=0000", rx); else pass_cnt++;
  endtask

  task automatic test_abort();
    logic [15:0] rx;
    push_pixel(1'b1, 1'b0, 12'h5A1);
    push_pixel(1'b1, 1'b1, 12'h5A2);
    spi_xfer(5, 1'b0, 0, 12'h000, rx);
    total_cnt++; if (abort_count !== 8'd1) $display("FAIL abort_count got=%0d exp=1", abort_count); else pass_cnt++;
    total_cnt++; if (fifo_level !== LW'(1)) $display("FAIL abort_level got=%0d exp=1", fifo_level); else pass_cnt++;
    spi_xfer(16, 1'b0, 0, 12'h000, rx);
    total_cnt++; if (rx !== exp_word(1'b1, 12'h5A2)) $display("FAIL abort_next got=%h exp=%h", rx, exp_word(1'b1, 12'h5A2)); else pass_cnt++;
    total_cnt++; if (abort_count !== 8'd1) $display("FAIL abort_full_xfer got=%0d exp=1", abort_count); else pass_cnt++;
  endtask

  // One push per transfer at a varying setup tick, so some pushes land on the pop cycle
  task automatic test_back_to_back();
    logic [15:0] rx, exp;
    logic [11:0] px;
    logic [15:0] q[$];
    for (int k = 0; k < 4; k++) begin
      push_pixel(1'b1, 1'b0, 12'hD00 + 12'(k));
      q.push_back(exp_word(1'b0, 12'hD00 + 12'(k)));
    end
    for (int t = 0; t < 3 * int'(DEPTH); t++) begin
      px = 12'hE00 + 12'(t);
      spi_xfer(16, 1'b1, t % 6, px, rx);
      exp = q.pop_front();
      q.push_back(exp_word(1'b0, px));
      total_cnt++; if (rx !== exp) $display("FAIL b2b_word[%0d] got=%h exp=%h", t, rx, exp); else pass_cnt++;
      total_cnt++; if (fifo_level !== LW'(4)) $display("FAIL b2b_level[%0d] got=%0d exp=4", t, fifo_level); else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] rx;
    push_pixel(1'b1, 1'b0, 12'h3C3);
    cs = 1'b0;
    repeat (10) tick();
    spi_bits(8, rx);
    RESET   = 1'b1;
    cs      = 1'b1;
    SPI_CLK = 1'b0;
    tick();
    total_cnt++; if (miso !== 1'b0) $display("FAIL rstmid_miso got=%b exp=0", miso); else pass_cnt++;
    total_cnt++; if (fifo_level !== LW'(0)) $display("FAIL rstmid_level got=%0d exp=0", fifo_level); else pass_cnt++;
    total_cnt++; if (overflow !== 1'b0) $display("FAIL rstmid_overflow got=%b exp=0", overflow); else pass_cnt++;
    total_cnt++; if (underrun !== 1'b0) $display("FAIL rstmid_underrun got=%b exp=0", underrun); else pass_cnt++;
    total_cnt++; if (abort_count !== 8'd0) $display("FAIL rstmid_abort got=%0d exp=0", abort_count); else pass_cnt++;
    RESET = 1'b0;
    repeat (5) tick();
    push_pixel(1'b1, 1'b1, 12'h7E7);
    spi_xfer(16, 1'b0, 0, 12'h000, rx);
    total_cnt++; if (rx !== exp_word(1'b1, 12'h7E7)) $display("FAIL rstmid_next got=%h exp=%h", rx, exp_word(1'b1, 12'h7E7)); else pass_cnt++;
    total_cnt++; if (abort_count !== 8'd0) $display("FAIL rstmid_abort_after got=%0d exp=0", abort_count); else pass_cnt++;
    total_cnt++; if (fifo_level !== LW'(0)) $display("FAIL rstmid_level_after got=%0d exp=0", fifo_level); else pass_cnt++;
  endtask

  initial begin
    RESET      = 1'b1;
    cs         = 1'b1;
    SPI_CLK    = 1'b0;
    capture_en = 1'b1;
    pix_valid  = 1'b0;
    pix_sof    = 1'b0;
    pix_data   = '0;
    test_reset();
    test_single_transfer();
    test_capture_gate();
    test_underrun();
    test_overflow();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
